// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sequencer.
package tts_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;
endpackage

// File: rtl/hold_timer.sv
// Per-vector hold counter; o_tc flags the last cycle of a vector's hold window.
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [7:0] r_count;

  assign o_tc = i_en && (r_count == 8'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= 8'd0;
    else if (i_clr)
      r_count <= 8'd0;
    else if (i_en)
      r_count <= o_tc ? 8'd0 : r_count + 8'd1;
  end
endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps {a,b,c} through 0..7, samples f_in at the end of each hold window
// and records which vectors disagree with EXPECT.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [7:0] EXPECT      = 8'b1110_1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_vec,
  output logic [3:0] err_count
);
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_fail_vec;
  logic [3:0]       r_err_count;
  logic             w_tc;
  logic             w_run;

  assign w_run = (r_state == ST_RUN);

  // Timer is held clear outside RUN so every sweep starts from count 0.
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (abort || !w_run),
    .i_en  (w_run),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_fail_vec  <= 8'h00;
      r_err_count <= 4'd0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_fail_vec  <= 8'h00;
      r_err_count <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_idx       <= '0;
            r_fail_vec  <= 8'h00;
            r_err_count <= 4'd0;
          end
        end
        ST_RUN: begin
          if (w_tc) begin
            if (f_in != EXPECT[r_idx]) begin
              r_fail_vec[r_idx] <= 1'b1;
              if (r_err_count != 4'(VEC_COUNT))
                r_err_count <= r_err_count + 4'd1;
            end
            if (r_idx == IDX_W'(VEC_COUNT - 1))
              r_state <= ST_DONE;
            else
              r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    {a, b, c} = 3'b000;
    if (r_state == ST_RUN)
      {a, b, c} = r_idx;
    else if (r_state == ST_DONE)
      {a, b, c} = 3'b111;
  end

  assign busy      = w_run;
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err_count == 4'd0);
  assign fail_vec  = r_fail_vec;
  assign err_count = r_err_count;
endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL provide parameter HOLD_CYCLES, default 10, meaning clock cycles each input vector is held (legal range 2..255).
REQ-002 The block SHALL provide parameter EXPECT, default 8'b1110_1000, meaning expected F for vector index i at bit i.
REQ-003 The block SHALL provide port clk  input  1  the single clock, with all logic on its rising edge.
REQ-004 The block SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL provide port start  input  1  one-cycle request to run the 8-vector sweep.
REQ-006 The block SHALL provide port abort  input  1  stop the sweep and return to idle.
REQ-007 The block SHALL provide port f_in  input  1  F output of the downstream logic under test.
REQ-008 The block SHALL provide ports a, b, c  output  1 each  driven inputs of the downstream logic under test.
REQ-009 The block SHALL provide port busy  output  1  high while the sweep runs.
REQ-010 The block SHALL provide port done  output  1  high after sweep completion until the next start, abort or reset.
REQ-011 The block SHALL provide port pass  output  1  done and zero mismatches.
REQ-012 The block SHALL provide port fail_vec  output  8  bit i set when vector i mismatched.
REQ-013 The block SHALL provide port err_count  output  4  number of mismatched vectors, 0..8.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 Vector index idx (3 bits) SHALL map to outputs as {a,b,c} = idx, with a as MSB; vectors SHALL be applied in order 0..7.
REQ-016 In IDLE or DONE, start=1 at a clock edge SHALL move the FSM to RUN with idx=0, hold counter=0, and fail_vec, err_count and done cleared.
REQ-017 start SHALL be ignored while in RUN.
REQ-018 In RUN, the hold counter SHALL increment each cycle; on the edge where the counter equals HOLD_CYCLES-1, f_in SHALL be sampled and compared to EXPECT[idx].
REQ-019 On a mismatch at that edge, fail_vec[idx] SHALL be set and err_count SHALL increment by 1.
REQ-020 On that same edge, if idx<7 the block SHALL increment idx and zero the counter; if idx==7 it SHALL enter DONE.
REQ-021 done SHALL rise exactly 8*HOLD_CYCLES cycles after the edge that accepted start.
REQ-022 busy SHALL equal (state==RUN); pass SHALL equal done && (err_count==0).
REQ-023 In IDLE, a,b,c SHALL be 0; in DONE, a,b,c SHALL hold 1,1,1.
REQ-024 abort=1 at any edge SHALL force IDLE with a,b,c=0 and done, fail_vec and err_count cleared; abort SHALL take priority over start and over the sampling edge in the same cycle.
REQ-025 err_count SHALL never exceed 8 and SHALL never wrap.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, idx=0, counter=0, a=b=c=0, busy=0, done=0, pass=0, fail_vec=8'h00 and err_count=0, including mid-sweep.
REQ-027 After rst_n deasserts, the first start SHALL be honoured on the first rising clock edge.

Structure
REQ-028 Shared package tts_pkg SHALL hold the state enum (IDLE, RUN, DONE), VEC_COUNT=8 and IDX_W=3.
REQ-029 One sub-module, hold_timer, SHALL implement the HOLD_CYCLES counter with clear and a terminal-count output; all other logic SHALL be in truth_table_sequencer.

Verification
REQ-030 The bench SHALL cover: HOLD_CYCLES=4, EXPECT=8'hE8, f_in from a correct majority model, start pulse -> a,b,c step 000..111 every 4 cycles, done at cycle 32, pass=1, fail_vec=8'h00, err_count=0.
REQ-031 The bench SHALL cover: same setup with f_in stuck at 0 -> done at 32, pass=0, fail_vec=8'hE8, err_count=4.
REQ-032 The bench SHALL cover: f_in inverted -> fail_vec=8'hFF, err_count=8 with no wrap.
REQ-033 The bench SHALL cover: abort asserted 10 cycles into RUN together with start -> IDLE next edge, a,b,c=000, busy=0, done=0, err_count=0.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-sweep (idx=5) -> all outputs at reset values without waiting for a clock edge; a subsequent start runs a full 32-cycle sweep.
REQ-035 The bench SHALL cover: start re-pulsed at cycle 6 of RUN -> ignored, done still at 32; start in DONE -> results cleared and a new sweep begins.
